// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: active-high glyph table,
// the all-off segment value and the output polarity helper.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Bit order g f e d c b a, active-high.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] polarity(input logic [6:0] x, input logic active_low);
        return x ^ {7{active_low}};
    endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational hex nibble to active-high 7-segment glyph, with a dark override.
module seg_glyph_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dark_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = dark_i ? SEG_OFF : GLYPH[nibble_i];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with a frame-synchronous shadow
// register, leading-zero suppression, per-digit blanking and a ghosting guard cycle.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  lz_en,
    output logic                  pending,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0] SEG_OFF_PIN = {7{ACTIVE_LOW}};

    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   sh_data_q, act_data_q;
    logic [DIGITS-1:0]     sh_dp_q, sh_blank_q, act_dp_q, act_blank_q;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;

    logic                  tc, commit;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blank, lead_zero, dark;
    logic [6:0]            glyph;
    logic [DIGITS-1:0]     an_hot;

    always_comb begin
        tc        = (div_q == DIV_LAST);
        commit    = tc && (idx_q == IDX_LAST) && pending_q;
        div_d     = tc ? '0 : div_q + 1'b1;
        idx_d     = idx_q;
        if (tc) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A load coinciding with a commit keeps pending set for the next frame.
        pending_d = load ? 1'b1 : (commit ? 1'b0 : pending_q);
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        lead_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = act_data_q[4*i +: 4];
                cur_dp    = act_dp_q[i];
                cur_blank = act_blank_q[i];
            end
            if (i >= int'(idx_q) && act_data_q[4*i +: 4] != 4'h0) begin
                lead_zero = 1'b0;
            end
        end
        dark = cur_blank || (lz_en && (idx_q != '0) && lead_zero);
    end

    seg_glyph_dec u_dec (
        .nibble_i (cur_nib),
        .dark_i   (dark),
        .glyph_o  (glyph)
    );

    always_comb begin
        an_hot = DIGITS'(1) << idx_q;
        seg_d  = SEG_OFF_PIN;
        dp_d   = ACTIVE_LOW;
        an_d   = AN_OFF;
        if (en) begin
            seg_d = polarity(glyph, ACTIVE_LOW);
            dp_d  = (cur_dp && !dark) ^ ACTIVE_LOW;
            // div == 0 is the guard cycle: no anode while segments settle.
            if (div_q != '0) begin
                an_d = an_hot ^ AN_OFF;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            idx_q       <= '0;
            sh_data_q   <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
            act_blank_q <= '0;
            pending_q   <= 1'b0;
            seg_q       <= SEG_OFF_PIN;
            dp_q        <= ACTIVE_LOW;
            an_q        <= AN_OFF;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            if (commit) begin
                act_data_q  <= sh_data_q;
                act_dp_q    <= sh_dp_q;
                act_blank_q <= sh_blank_q;
            end
            if (load) begin
                sh_data_q  <= data;
                sh_dp_q    <= dp_in;
                sh_blank_q <= blank_in;
            end
        end
    end

    assign pending = pending_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised and directed checks of seg_scan_driver (active-low and active-high
// instances) against a frame-level reference model.
module tb_seg_scan_driver;

    localparam int D  = 4;
    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en, load, lz_en;
    logic [15:0] data;
    logic [3:0]  dp_in, blank_in;

    logic        pend_l, pend_h;
    logic [6:0]  seg_l, seg_h;
    logic        dp_l, dp_h;
    logic [3:0]  an_l, an_h;

    int n_checks = 0;
    int n_pass   = 0;

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
        .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
        .pending(pend_l), .seg_o(seg_l), .dp_o(dp_l), .an_o(an_l)
    );

    seg_scan_driver #(.DIGITS(D), .SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data),
        .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
        .pending(pend_h), .seg_o(seg_h), .dp_o(dp_h), .an_o(an_h)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: a frame is D slots of SD cycles; t counts cycles since reset.
    logic [6:0]  glyph_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    int          t;
    logic [15:0] sh_data, act_data;
    logic [3:0]  sh_dp, sh_bl, act_dp, act_bl;
    logic        pend;
    logic [12:0] exp_q[$];

    int          m_dv, m_ix;
    logic [3:0]  m_an, m_nib;
    logic [6:0]  m_seg;
    logic        m_dp, m_dark, m_commit;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0; pend = 1'b0;
            sh_data = '0; sh_dp = '0; sh_bl = '0;
            act_data = '0; act_dp = '0; act_bl = '0;
            exp_q.delete();
        end else begin
            m_dv = t % SD;
            m_ix = (t / SD) % D;
            m_an = '0; m_seg = '0; m_dp = 1'b0;
            if (en) begin
                m_nib  = 4'(act_data >> (4 * m_ix));
                m_dark = act_bl[m_ix] || (lz_en && m_ix != 0 && (act_data >> (4 * m_ix)) == 0);
                if (m_dv != 0) m_an = 4'(1 << m_ix);
                if (!m_dark) begin
                    m_seg = glyph_tab[m_nib];
                    m_dp  = act_dp[m_ix];
                end
            end
            m_commit = (m_dv == SD - 1) && (m_ix == D - 1) && pend;
            if (m_commit) begin
                act_data = sh_data; act_dp = sh_dp; act_bl = sh_bl;
            end
            if (load) begin
                sh_data = data; sh_dp = dp_in; sh_bl = blank_in; pend = 1'b1;
            end else if (m_commit) begin
                pend = 1'b0;
            end
            t++;
            exp_q.push_back({pend, m_an, m_seg, m_dp});
        end
    end

    // Scoreboard: compare both instances on the falling edge.
    logic [12:0] e;
    logic [3:0]  e_an_n;
    logic [6:0]  e_seg_n;
    logic        e_dp_n;
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            e_an_n  = ~e[11:8];
            e_seg_n = ~e[7:1];
            e_dp_n  = ~e[0];
            check("pend_l", pend_l, e[12]);
            check("an_l",   an_l,   e_an_n);
            check("seg_l",  seg_l,  e_seg_n);
            check("dp_l",   dp_l,   e_dp_n);
            check("pend_h", pend_h, e[12]);
            check("an_h",   an_h,   e[11:8]);
            check("seg_h",  seg_h,  e[7:1]);
            check("dp_h",   dp_h,   e[0]);
        end
    end

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            load = 1'b0;
        end
    endtask

    task automatic set_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        data = d; dp_in = dp; blank_in = bl; load = 1'b1;
    endtask

    task automatic check_all_off(input string tag);
        check({tag, "_an_l"},  an_l,  4'hF);
        check({tag, "_seg_l"}, seg_l, 7'h7F);
        check({tag, "_dp_l"},  dp_l,  1'b1);
        check({tag, "_pend"},  pend_l, 1'b0);
        check({tag, "_an_h"},  an_h,  4'h0);
        check({tag, "_seg_h"}, seg_h, 7'h00);
    endtask

    initial begin
        int k;
        en = 1'b1; load = 1'b0; lz_en = 1'b0;
        data = '0; dp_in = '0; blank_in = '0;
        repeat (3) @(negedge clk);
        check_all_off("rst");
        rst_n = 1'b1;

        set_load(16'h1234, 4'b0000, 4'b0000); run(40);
        lz_en = 1'b1;
        set_load(16'h00A0, 4'b0000, 4'b0000); run(40);
        set_load(16'h0000, 4'b0000, 4'b0000); run(40);
        lz_en = 1'b0;
        set_load(16'h1111, 4'b0000, 4'b0000); @(negedge clk);
        set_load(16'h2222, 4'b0000, 4'b0000); run(40);

        // Load landing exactly on the commit cycle.
        set_load(16'h5678, 4'b0000, 4'b0000); run(1);
        for (k = 0; k < 64 && !((t % SD == SD - 1) && ((t / SD) % D == D - 1)); k++) @(negedge clk);
        check("commit_slot_found", (k < 64), 1'b1);
        set_load(16'h9ABC, 4'b0000, 4'b0000); run(40);

        set_load(16'hCDEF, 4'b0100, 4'b1000); run(40);
        en = 1'b0; run(12);
        en = 1'b1; run(12);

        // Asynchronous reset in the middle of a slot.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_off("arst");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(20);

        repeat (600) begin
            @(negedge clk);
            load = ($urandom_range(0, 7) == 0);
            if (load) begin
                data     = 16'($urandom >> (4 * $urandom_range(0, 4)));
                dp_in    = 4'($urandom);
                blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
            en = ($urandom_range(0, 15) != 0);
        end
        @(negedge clk);
        load = 1'b0;
        run(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
